lcd_bus_ctrl: RTL and testbench

//  HD44780 character-LCD write controller between myProc output word and LCD pins.

---
 rtl/lcd_bus_pkg.sv | 45 ++++
 rtl/lcd_delay_cnt.sv | 39 +++
 rtl/lcd_bus_ctrl.sv | 179 +++++++++++++++++
 tb/tb_lcd_bus_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_bus_pkg.sv
// lcd_bus_pkg: shared definitions for the HD44780 write controller.
//   lcd_state_e   controller state encoding
//   INIT_LEN      number of bytes in the power-on init sequence
//   CMD_CLEAR/HOME instruction bytes that need the long post-command wait
//   init_byte()   init sequence table lookup
//   phase_m1()    counter load value for a phase length (0 treated as 1)
//   is_long_cmd() selects the clear/home wait
package lcd_bus_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } lcd_state_e;

    localparam int unsigned INIT_LEN  = 5;
    localparam logic [7:0]  CMD_CLEAR = 8'h01;
    localparam logic [7:0]  CMD_HOME  = 8'h02;

    // Function set (8-bit, 2 lines), display on, entry mode, clear.
    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h38;
            3'd1:    return 8'h38;
            3'd2:    return 8'h0C;
            3'd3:    return 8'h06;
            default: return CMD_CLEAR;
        endcase
    endfunction

    // A phase of length t lasts t counter values (t-1 .. 0); zero-length phases
    // are stretched to one cycle.
    function automatic int unsigned phase_m1(input int unsigned t);
        return (t == 0) ? 0 : t - 1;
    endfunction

    // Clear (0x01) and home (0x02/0x03) instructions: RS=0, data[7:2]==0, data[1:0]!=0.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
        return !rs && ((d == CMD_CLEAR) || (d[7:1] == CMD_HOME[7:1]));
    endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// lcd_delay_cnt: loadable down counter that stops at zero.
//   clk, rst        clock, synchronous active-high reset (loads RST_VAL)
//   load, load_val  load a new count this edge
//   zero            count has reached zero
module lcd_delay_cnt
    import lcd_bus_pkg::*;
#(
    parameter int unsigned     CNTW    = 20,
    parameter logic [CNTW-1:0] RST_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [CNTW-1:0] load_val,
    output logic            zero
);

    logic [CNTW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_ctrl.sv
// lcd_bus_ctrl: HD44780 character-LCD write controller.
// Accepts one byte + RS flag per valid/ready handshake and generates the
// setup / EN pulse / hold bus timing followed by the post-command busy wait.
//   clk, rst              clock, synchronous active-high reset
//   wr_valid/wr_rs/wr_data  processor write offer (RS: 0 = instr, 1 = data)
//   wr_ready, busy        handshake ready and its inverse
//   LCD_Data/EN/RS/RW     LCD pins (RW tied low, write only)
// Build option: define LCD_INIT_EN to issue the power-on init sequence
// automatically before the first processor write is accepted.
module lcd_bus_ctrl
    import lcd_bus_pkg::*;
#(
    parameter int unsigned T_PWRUP = 750000,
    parameter int unsigned T_SETUP = 4,
    parameter int unsigned T_EN    = 12,
    parameter int unsigned T_HOLD  = 4,
    parameter int unsigned T_CMD   = 2000,
    parameter int unsigned T_CLR   = 82000,
    parameter int unsigned CNTW    = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       busy,
    output logic [7:0] LCD_Data,
    output logic       LCD_EN,
    output logic       LCD_RS,
    output logic       LCD_RW
);

    localparam logic [CNTW-1:0] LD_PWRUP = CNTW'(phase_m1(T_PWRUP));
    localparam logic [CNTW-1:0] LD_SETUP = CNTW'(phase_m1(T_SETUP));
    localparam logic [CNTW-1:0] LD_EN    = CNTW'(phase_m1(T_EN));
    localparam logic [CNTW-1:0] LD_HOLD  = CNTW'(phase_m1(T_HOLD));
    localparam logic [CNTW-1:0] LD_CMD   = CNTW'(phase_m1(T_CMD));
    localparam logic [CNTW-1:0] LD_CLR   = CNTW'(phase_m1(T_CLR));

    lcd_state_e      state_q, state_d;
    logic [7:0]      lcd_data_q, lcd_data_d;
    logic            lcd_rs_q, lcd_rs_d;
    logic            lcd_en_q, lcd_en_d;
    logic            wr_ready_q, wr_ready_d;
    logic            cnt_load;
    logic [CNTW-1:0] cnt_load_val;
    logic            cnt_zero;
    logic            accept;
`ifdef LCD_INIT_EN
    logic [2:0]      init_idx_q, init_idx_d;
`endif

    assign accept = wr_valid && wr_ready_q;

    lcd_delay_cnt #(
        .CNTW    (CNTW),
        .RST_VAL (LD_PWRUP)
    ) u_dly (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        lcd_data_d   = lcd_data_q;
        lcd_rs_d     = lcd_rs_q;
        lcd_en_d     = lcd_en_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
`ifdef LCD_INIT_EN
        init_idx_d   = init_idx_q;
`endif
        // Ready is registered from the previous cycle's IDLE state, which adds
        // the one cycle between entering IDLE and advertising ready.
        wr_ready_d   = (state_q == ST_IDLE) && !accept;

        case (state_q)
            ST_PWRUP: begin
                if (cnt_zero) begin
`ifdef LCD_INIT_EN
                    lcd_data_d   = init_byte(3'd0);
                    lcd_rs_d     = 1'b0;
                    init_idx_d   = 3'd1;
                    cnt_load     = 1'b1;
                    cnt_load_val = LD_SETUP;
                    state_d      = ST_SETUP;
`else
                    state_d      = ST_IDLE;
`endif
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    lcd_data_d   = wr_data;
                    lcd_rs_d     = wr_rs;
                    cnt_load     = 1'b1;
                    cnt_load_val = LD_SETUP;
                    state_d      = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    lcd_en_d     = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = LD_EN;
                    state_d      = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (cnt_zero) begin
                    lcd_en_d     = 1'b0;
                    cnt_load     = 1'b1;
                    cnt_load_val = LD_HOLD;
                    state_d      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = is_long_cmd(lcd_rs_q, lcd_data_q) ? LD_CLR : LD_CMD;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_zero) begin
`ifdef LCD_INIT_EN
                    if (init_idx_q != 3'(INIT_LEN)) begin
                        lcd_data_d   = init_byte(init_idx_q);
                        lcd_rs_d     = 1'b0;
                        init_idx_d   = init_idx_q + 3'd1;
                        cnt_load     = 1'b1;
                        cnt_load_val = LD_SETUP;
                        state_d      = ST_SETUP;
                    end else begin
                        state_d      = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            default: state_d = ST_PWRUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_PWRUP;
            lcd_data_q <= '0;
            lcd_rs_q   <= 1'b0;
            lcd_en_q   <= 1'b0;
            wr_ready_q <= 1'b0;
`ifdef LCD_INIT_EN
            init_idx_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            lcd_data_q <= lcd_data_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_en_q   <= lcd_en_d;
            wr_ready_q <= wr_ready_d;
`ifdef LCD_INIT_EN
            init_idx_q <= init_idx_d;
`endif
        end
    end

    assign wr_ready = wr_ready_q;
    assign busy     = ~wr_ready_q;
    assign LCD_Data = lcd_data_q;
    assign LCD_EN   = lcd_en_q;
    assign LCD_RS   = lcd_rs_q;
    assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// tb_lcd_bus_ctrl: directed self-checking bench for lcd_bus_ctrl.
// Observed vector layout everywhere: {LCD_Data, LCD_RS, LCD_EN, LCD_RW, wr_ready, busy}.
// Build with LCD_INIT_EN defined to exercise the automatic init sequence.
module tb_lcd_bus_ctrl;

    localparam int unsigned P_PWRUP = 20;
    localparam int unsigned P_SETUP = 2;
    localparam int unsigned P_EN    = 3;
    localparam int unsigned P_HOLD  = 2;
    localparam int unsigned P_CMD   = 10;
    localparam int unsigned P_CLR   = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_rs = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready, busy, LCD_EN, LCD_RS, LCD_RW;
    logic [7:0] LCD_Data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lcd_bus_ctrl #(
        .T_PWRUP (P_PWRUP),
        .T_SETUP (P_SETUP),
        .T_EN    (P_EN),
        .T_HOLD  (P_HOLD),
        .T_CMD   (P_CMD),
        .T_CLR   (P_CLR),
        .CNTW    (20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_rs    (wr_rs),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .busy     (busy),
        .LCD_Data (LCD_Data),
        .LCD_EN   (LCD_EN),
        .LCD_RS   (LCD_RS),
        .LCD_RW   (LCD_RW)
    );

    // Reset for two edges, then power-up wait: ready low for P_PWRUP samples, then high.
    task automatic test_reset();
        logic [12:0] obs, exp;
        @(negedge clk);
        rst = 1'b1;
        wr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        obs = {LCD_Data, LCD_RS, LCD_EN, LCD_RW, wr_ready, busy};
        exp = {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs, exp);
        end
        rst = 1'b0;
        for (int i = 1; i <= int'(P_PWRUP); i++) begin
            @(negedge clk);
            obs = {LCD_Data, LCD_RS, LCD_EN, LCD_RW, wr_ready, busy};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL pwrup_cycle_%0d: got %h expected %h", i, obs, exp);
            end
        end
        @(negedge clk);
        obs = {LCD_Data, LCD_RS, LCD_EN, LCD_RW, wr_ready, busy};
        exp = {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL pwrup_ready: got %h expected %h", obs, exp);
        end
    endtask

    // One handshake write, checked every cycle from the accept edge (k=0) until
    // ready returns at k = setup+en+hold+wait+1. With hold set, wr_valid stays
    // high and wr_data/wr_rs are scrambled while busy; they must be ignored.
    task automatic run_xfer(input logic rs, input logic [7:0] d, input int unsigned wt,
                            input bit hold, input string name);
        int unsigned lat;
        int          guard;
        logic        exp_en, exp_rdy;
        logic [12:0] obs, exp;
        lat   = P_SETUP + P_EN + P_HOLD + wt + 1;
        guard = 0;
        while (wr_ready !== 1'b1 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (wr_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_ready_timeout: got wr_ready=%b expected 1", name, wr_ready);
            return;
        end
        wr_valid = 1'b1;
        wr_rs    = rs;
        wr_data  = d;
        for (int unsigned k = 0; k <= lat; k++) begin
            @(negedge clk);
            exp_en  = (k >= P_SETUP) && (k < P_SETUP + P_EN);
            exp_rdy = (k == lat);
            obs = {LCD_Data, LCD_RS, LCD_EN, LCD_RW, wr_ready, busy};
            exp = {d, rs, exp_en, 1'b0, exp_rdy, ~exp_rdy};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL %s_k%0d: got %h expected %h", name, k, obs, exp);
            end
            if (!hold) begin
                wr_valid = 1'b0;
            end else if (k != lat) begin
                wr_data = d ^ (8'h80 | 8'(k));
                wr_rs   = ~rs;
            end
        end
    endtask

    task automatic test_write_data();
        run_xfer(1'b1, 8'h41, P_CMD, 1'b0, "data_41");
    endtask

    task automatic test_wait_len();
        run_xfer(1'b0, 8'h01, P_CLR, 1'b0, "clear");
        run_xfer(1'b0, 8'h04, P_CMD, 1'b0, "instr_04");
        run_xfer(1'b1, 8'h01, P_CMD, 1'b0, "data_01");
        run_xfer(1'b0, 8'h02, P_CLR, 1'b0, "home_02");
        run_xfer(1'b0, 8'h03, P_CLR, 1'b0, "home_03");
        run_xfer(1'b0, 8'h00, P_CMD, 1'b0, "instr_00");
        run_xfer(1'b0, 8'h80, P_CMD, 1'b0, "instr_80");
    endtask

    task automatic test_back_to_back();
        run_xfer(1'b1, 8'h55, P_CMD, 1'b1, "b2b_0");
        run_xfer(1'b0, 8'h0C, P_CMD, 1'b1, "b2b_1");
        run_xfer(1'b1, 8'h33, P_CMD, 1'b0, "b2b_2");
    endtask

    // Reset asserted while EN is high: everything clears on the next edge.
    task automatic test_reset_mid();
        int          guard;
        logic [12:0] obs, exp;
        guard = 0;
        while (wr_ready !== 1'b1 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        wr_valid = 1'b1;
        wr_rs    = 1'b1;
        wr_data  = 8'h5A;
        @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        obs = {LCD_Data, LCD_RS, LCD_EN, LCD_RW, wr_ready, busy};
        exp = {8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL rstmid_pulse: got %h expected %h", obs, exp);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        obs = {LCD_Data, LCD_RS, LCD_EN, LCD_RW, wr_ready, busy};
        exp = {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL rstmid_abort: got %h expected %h", obs, exp);
        end
        for (int i = 1; i <= int'(P_PWRUP); i++) begin
            @(negedge clk);
            n_tests++;
            if (wr_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_pwrup_%0d: got wr_ready=%b expected 0", i, wr_ready);
            end
        end
        @(negedge clk);
        n_tests++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_ready: got wr_ready=%b expected 1", wr_ready);
        end
    endtask

`ifdef LCD_INIT_EN
    // Init sequence with a write offered throughout; it must not be accepted.
    task automatic test_init();
        logic [7:0]  init_b [5];
        int unsigned wt;
        logic        exp_en;
        logic [12:0] obs, exp;
        init_b = '{8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
        @(negedge clk);
        rst      = 1'b1;
        wr_valid = 1'b1;
        wr_rs    = 1'b1;
        wr_data  = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp = {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 1; i < int'(P_PWRUP); i++) begin
            @(negedge clk);
            obs = {LCD_Data, LCD_RS, LCD_EN, LCD_RW, wr_ready, busy};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL init_pwrup_%0d: got %h expected %h", i, obs, exp);
            end
        end
        for (int b = 0; b < 5; b++) begin
            wt = (b == 4) ? P_CLR : P_CMD;
            for (int unsigned k = 0; k < P_SETUP + P_EN + P_HOLD + wt; k++) begin
                @(negedge clk);
                exp_en = (k >= P_SETUP) && (k < P_SETUP + P_EN);
                obs = {LCD_Data, LCD_RS, LCD_EN, LCD_RW, wr_ready, busy};
                exp = {init_b[b], 1'b0, exp_en, 1'b0, 1'b0, 1'b1};
                n_tests++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL init_b%0d_k%0d: got %h expected %h", b, k, obs, exp);
                end
            end
        end
        @(negedge clk);
        obs = {LCD_Data, LCD_RS, LCD_EN, LCD_RW, wr_ready, busy};
        exp = {8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL init_idle: got %h expected %h", obs, exp);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        obs = {LCD_Data, LCD_RS, LCD_EN, LCD_RW, wr_ready, busy};
        exp = {8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL init_ready: got %h expected %h", obs, exp);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef LCD_INIT_EN
        test_init();
        run_xfer(1'b1, 8'h41, P_CMD, 1'b0, "post_init");
`else
        test_reset();
        test_write_data();
        test_wait_len();
        test_back_to_back();
        test_reset_mid();
        run_xfer(1'b1, 8'h7E, P_CMD, 1'b0, "post_rst");
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
